fifo_word_packer: RTL

//  Downstream consumer of the synchronous byte FIFO. Pops bytes through the FIFO read port
//  (rd_data / rd_ena / rd_empty, first-word fall-through) and packs RATIO bytes into one word.

---
 rtl/fifo_word_packer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_word_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : fifo_word_packer
// Description : Pops bytes from a first-word-fall-through FIFO read port and
//               packs RATIO bytes per output word. Words leave on a
//               valid/ready stream with a contiguous byte-keep mask. Partial
//               words go out on flush or after an idle timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module fifo_word_packer #(
   parameter int WIDTH   = 8,
   parameter int RATIO   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         rd_data,
   input  logic                     rd_empty,
   output logic                     rd_ena,
   input  logic                     flush,
   output logic [WIDTH*RATIO-1:0]   o_data,
   output logic [RATIO-1:0]         o_keep,
   output logic                     o_valid,
   input  logic                     o_ready
);

   localparam int CW = $clog2(RATIO);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

   logic [RATIO-2:0][WIDTH-1:0] r_acc;
   logic [CW-1:0]               r_cnt;
   logic                        r_pend;
   logic [WIDTH*RATIO-1:0]      r_data;
   logic [RATIO-1:0]            r_keep;
   logic                        r_valid;

   logic                        w_slot_free;
   logic                        w_pop;
   logic                        w_full;
   logic [CW:0]                 w_cnt_after;
   logic                        w_tmo;
   logic                        w_pend;
   logic                        w_emit;
   logic                        w_load;
   logic [WIDTH*RATIO-1:0]      w_word;
   logic [RATIO-1:0]            w_keep;

   // Output slot can take a new word when empty or being drained this cycle.
   assign w_slot_free = ~r_valid | o_ready;
   // The last byte of a word may only be popped when the output slot is free.
   assign w_pop       = rst_n & ~rd_empty & ((r_cnt != LAST) | w_slot_free);
   assign w_full      = w_pop & (r_cnt == LAST);
   // Byte count including a byte popped this cycle.
   assign w_cnt_after = {1'b0, r_cnt} + (CW+1)'(w_pop);
   assign w_pend      = r_pend | flush | w_tmo;
   // Partial emission: a completing pop always wins over a pending flush.
   assign w_emit      = w_pend & ~w_full & (w_cnt_after != '0) & w_slot_free;
   assign w_load      = w_full | w_emit;

   assign rd_ena  = w_pop;
   assign o_data  = r_data;
   assign o_keep  = r_keep;
   assign o_valid = r_valid;

   // Word assembly: stored lanes, then the byte popped this cycle, zeros above.
   for (genvar i = 0; i < RATIO; i++) begin : g_lane
      if (i < RATIO - 1) begin : g_acc
         assign w_word[i*WIDTH +: WIDTH] =
            ((CW+1)'(i) < {1'b0, r_cnt})                 ? r_acc[i] :
            (((CW+1)'(i) == {1'b0, r_cnt}) && w_pop)     ? rd_data  : '0;
      end else begin : g_last
         assign w_word[i*WIDTH +: WIDTH] = w_full ? rd_data : '0;
      end
      assign w_keep[i] = ((CW+1)'(i) < w_cnt_after);
   end

   if (TIMEOUT > 0) begin : g_timer
      logic [TW-1:0] r_timer;
      assign w_tmo = (r_timer == TW'(TIMEOUT));
      // Idle timer: runs while a partial word waits with no pop, saturates at TIMEOUT.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_timer <= '0;
         end else if (w_pop || w_load || (r_cnt == '0)) begin
            r_timer <= '0;
         end else if (!w_tmo) begin
            r_timer <= r_timer + TW'(1);
         end
      end
   end else begin : g_no_timer
      assign w_tmo = 1'b0;
   end

   // Accumulator, byte count and flush-pending state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_pend <= 1'b0;
      end else begin
         if (w_pop && !w_full) begin
            r_acc[r_cnt] <= rd_data;
         end
         r_cnt  <= w_load ? '0 : w_cnt_after[CW-1:0];
         r_pend <= w_pend & ~w_load & (w_cnt_after != '0);
      end
   end

   // Output register: load a finished word, hold under backpressure, drop on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_keep  <= '0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_data  <= w_word;
         r_keep  <= w_keep;
         r_valid <= 1'b1;
      end else if (o_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire
